// File: rtl/seg_scan_ctrl_if.sv
// Display-content load handshake and segment/anode drive bundle for seg_scan_ctrl.
// The master side supplies content and the load strobe. The slave side is the scan controller.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic [NUM_DIGITS-1:0]   blink_in;
  logic                    load;
  logic                    load_ack;
  logic                    frame_tick;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;

  modport master (
    output digits, dp_in, blank_in, blink_in, load,
    input  load_ack, frame_tick, seg, dp, an
  );

  modport slave (
    input  digits, dp_in, blank_in, blink_in, load,
    output load_ack, frame_tick, seg, dp, an
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed N-digit 7-segment scanner with a refresh prescaler, dead-time ghost blanking,
// blink and blank controls, and content staging that only commits at frame boundaries.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 50
) (
  input logic           clk,
  input logic           clr,
  seg_scan_ctrl_if.slave bus
);

  localparam int PSC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BF_W  = $clog2(BLINK_FRAMES + 1);

  localparam logic [PSC_W-1:0] PSC_LAST  = PSC_W'(CLK_DIV - 1);
  localparam logic [PSC_W-1:0] BLANK_END = PSC_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BF_W-1:0]  BF_LAST   = BF_W'(BLINK_FRAMES - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan position and blink state
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BF_W-1:0]  frame_q, frame_d;
  logic             phase_q, phase_d;

  // Staged (pending) and active display content
  logic                    pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0] stg_digits_q, stg_digits_d, act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   stg_blank_q, stg_blank_d, act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0]   stg_blink_q, stg_blink_d, act_blink_q, act_blink_d;

  // Registered outputs
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  ack_q, ack_d;
  logic                  tick_q, tick_d;

  logic at_wrap, at_fb, commit, dead, dark;

  always_comb begin
    // NOTE: every next-state signal takes a default before any branch, so no path can infer a latch.
    psc_d        = psc_q;
    idx_d        = idx_q;
    frame_d      = frame_q;
    phase_d      = phase_q;
    pend_d       = pend_q;
    stg_digits_d = stg_digits_q;
    stg_dp_d     = stg_dp_q;
    stg_blank_d  = stg_blank_q;
    stg_blink_d  = stg_blink_q;
    act_digits_d = act_digits_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    act_blink_d  = act_blink_q;
    an_d         = '1;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;

    at_wrap = (psc_q == PSC_LAST);
    at_fb   = at_wrap && (idx_q == IDX_LAST);
    commit  = at_fb && pend_q;

    psc_d = at_wrap ? '0 : psc_q + 1'b1;
    if (at_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    // A load on the boundary cycle is staged behind the commit of the older content.
    if (bus.load) begin
      stg_digits_d = bus.digits;
      stg_dp_d     = bus.dp_in;
      stg_blank_d  = bus.blank_in;
      stg_blink_d  = bus.blink_in;
    end
    pend_d = bus.load | (pend_q & ~commit);

    if (commit) begin
      act_digits_d = stg_digits_q;
      act_dp_d     = stg_dp_q;
      act_blank_d  = stg_blank_q;
      act_blink_d  = stg_blink_q;
    end

    if (at_fb) begin
      if (frame_q == BF_LAST) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end

    dead = (psc_q < BLANK_END);
    dark = act_blank_q[idx_q] | (act_blink_q[idx_q] & phase_q);
    if (!dead && !dark) begin
      an_d[idx_q] = 1'b0;
      seg_d       = hex_to_seg(act_digits_q[4*idx_q +: 4]);
      dp_d        = ~act_dp_q[idx_q];
    end

    ack_d  = commit;
    tick_d = at_fb;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      psc_q        <= '0;
      idx_q        <= '0;
      frame_q      <= '0;
      phase_q      <= 1'b0;
      pend_q       <= 1'b0;
      stg_digits_q <= '0;
      stg_dp_q     <= '0;
      stg_blank_q  <= '1;
      stg_blink_q  <= '0;
      act_digits_q <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '1;
      act_blink_q  <= '0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
      ack_q        <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      psc_q        <= psc_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      phase_q      <= phase_d;
      pend_q       <= pend_d;
      stg_digits_q <= stg_digits_d;
      stg_dp_q     <= stg_dp_d;
      stg_blank_q  <= stg_blank_d;
      stg_blink_q  <= stg_blink_d;
      act_digits_q <= act_digits_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      act_blink_q  <= act_blink_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      ack_q        <= ack_d;
      tick_q       <= tick_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.load_ack   = ack_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 digits, 8-cycle slots, 2 dead cycles and a 2-frame blink.
// k counts clock edges since reset release, so a 32-cycle frame starts at every k that is a multiple of 32.
module tb_seg_scan_ctrl;

  logic clk;
  logic clr;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   k        = 0;
  int   ack_k    = -1;

  seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .CLK_DIV     (8),
    .BLANK_CYCLES(2),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at k=%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  // Advance to edge count 'target'. The frame_tick and load_ack outputs are compared on every edge.
  task automatic run_to(input int target);
    while (k < target) begin
      @(posedge clk);
      #1;
      k++;
      check("frame_tick", 32'(bus.frame_tick), 32'((k % 32) == 0));
      check("load_ack", 32'(bus.load_ack), 32'(k == ack_k));
    end
  endtask

  task automatic run_dark(input string tag, input int target);
    while (k < target) begin
      run_to(k + 1);
      check(tag, 32'({bus.an, bus.seg, bus.dp}), 32'({4'hF, 7'h7F, 1'b1}));
    end
  endtask

  // The slot starts at edge count s. Its outputs appear one cycle later. The first two cycles are dead time.
  task automatic chk_slot(input string tag, input int s, input logic [3:0] an_e,
                          input logic [6:0] seg_e, input logic dp_e);
    for (int p = 0; p < 8; p++) begin
      run_to(s + 1 + p);
      if (p < 2)
        check({tag, "_dead"}, 32'({bus.an, bus.seg, bus.dp}), 32'({4'hF, 7'h7F, 1'b1}));
      else
        check(tag, 32'({bus.an, bus.seg, bus.dp}), 32'({an_e, seg_e, dp_e}));
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dpv,
                         input logic [3:0] bl, input logic [3:0] bk);
    bus.digits   = d;
    bus.dp_in    = dpv;
    bus.blank_in = bl;
    bus.blink_in = bk;
    bus.load     = 1'b1;
    run_to(k + 1);
    bus.load     = 1'b0;
  endtask

  initial begin
    bus.digits   = '0;
    bus.dp_in    = '0;
    bus.blank_in = '0;
    bus.blink_in = '0;
    bus.load     = 1'b0;
    clr          = 1'b1;
    #1 clr = 1'b0;
    #1;
    check("rst_seg", 32'(bus.seg), 32'h7F);
    check("rst_dp", 32'(bus.dp), 32'h1);
    check("rst_an", 32'(bus.an), 32'hF);
    check("rst_ack", 32'(bus.load_ack), 32'h0);
    check("rst_tick", 32'(bus.frame_tick), 32'h0);
    @(negedge clk);
    clr = 1'b1;
    k   = 0;

    // 1: three idle frames stay dark and produce no ack.
    run_dark("idle_dark", 96);

    // 2: first commit lands with the frame tick at edge 128.
    do_load(16'h1234, 4'b0001, 4'b0000, 4'b0000);
    ack_k = 128;
    chk_slot("t2_slot0", 128, 4'b1110, 7'h19, 1'b0);
    chk_slot("t2_slot1", 136, 4'b1101, 7'h30, 1'b1);
    chk_slot("t2_slot2", 144, 4'b1011, 7'h24, 1'b1);
    chk_slot("t2_slot3", 152, 4'b0111, 7'h79, 1'b1);

    // 3: two loads in one frame produce a single ack. The last load wins, and nothing changes mid-frame.
    run_to(160);
    do_load(16'h1111, 4'b0000, 4'b0000, 4'b0000);
    run_to(170);
    do_load(16'hABCD, 4'b0000, 4'b0000, 4'b0000);
    ack_k = 192;
    chk_slot("t3_old_slot3", 184, 4'b0111, 7'h79, 1'b1);
    chk_slot("t3_slot0", 192, 4'b1110, 7'h21, 1'b1);
    chk_slot("t3_slot1", 200, 4'b1101, 7'h46, 1'b1);
    chk_slot("t3_slot2", 208, 4'b1011, 7'h03, 1'b1);
    chk_slot("t3_slot3", 216, 4'b0111, 7'h08, 1'b1);

    // 4: a load on the boundary cycle with nothing pending commits one frame later.
    run_to(255);
    do_load(16'h5678, 4'b1000, 4'b0000, 4'b0000);
    ack_k = 288;
    chk_slot("t4_still_old", 256, 4'b1110, 7'h21, 1'b1);
    chk_slot("t4_slot0", 288, 4'b1110, 7'h00, 1'b1);
    chk_slot("t4_slot3", 312, 4'b0111, 7'h12, 1'b0);

    // 5: blink on digit 2. Phase is 1 during 352-383 and 448-511, and 0 during 384-447 and 512-575.
    run_to(320);
    do_load(16'h5678, 4'b0000, 4'b0000, 4'b0100);
    ack_k = 352;
    chk_slot("t5_dark_a", 368, 4'hF, 7'h7F, 1'b1);
    chk_slot("t5_lit_a", 400, 4'b1011, 7'h02, 1'b1);
    chk_slot("t5_lit_b", 432, 4'b1011, 7'h02, 1'b1);
    chk_slot("t5_other", 456, 4'b1101, 7'h78, 1'b1);
    chk_slot("t5_dark_b", 464, 4'hF, 7'h7F, 1'b1);
    chk_slot("t5_dark_c", 496, 4'hF, 7'h7F, 1'b1);
    chk_slot("t5_lit_c", 528, 4'b1011, 7'h02, 1'b1);

    // 6: reset mid-slot with a staged load discards that content.
    run_to(547);
    do_load(16'h9999, 4'b1111, 4'b0000, 4'b0000);
    run_to(550);
    check("t6_pre", 32'({bus.an, bus.seg, bus.dp}), 32'({4'b1110, 7'h00, 1'b1}));
    clr = 1'b0;
    #1;
    check("t6_rst_out", 32'({bus.an, bus.seg, bus.dp}), 32'({4'hF, 7'h7F, 1'b1}));
    check("t6_rst_hs", 32'({bus.load_ack, bus.frame_tick}), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr   = 1'b1;
    k     = 0;
    ack_k = -1;
    run_dark("t6_dark", 70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
